mem_arb: RTL and testbench

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb.sv | 90 +++++++++
 tb/tb_mem_arb.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Arbitrates one single-port memory between a wishbone slave port and an engine.
// The engine has priority; a wishbone request waits a bounded time unless the engine locks.
module mem_arb #(
   parameter int MAX_WAIT = 8
) (
   input  logic        clk,
   input  logic        RST,
   input  logic        wb_cyc,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [4:0]  wb_addr,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack,
   input  logic        eng_req,
   input  logic        eng_lock,
   input  logic        eng_we_n,
   input  logic [4:0]  eng_addr,
   input  logic [31:0] eng_wdata,
   output logic        eng_gnt,
   output logic [31:0] eng_rdata,
   output logic        mem_we_n,
   output logic [4:0]  mem_addr,
   output logic [31:0] mem_datain,
   input  logic [31:0] mem_dataout
);

   typedef enum logic [1:0] {IDLE, WB_ACC, WB_ACK} state_t;

   localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

   state_t     state;
   logic [3:0] wait_cnt;
   logic       pending;

   assign pending   = (state == IDLE) && wb_cyc && wb_stb;
   assign eng_rdata = mem_dataout;

   always_ff @(posedge clk) begin
      if (RST) begin
         state    <= IDLE;
         wait_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (!pending) begin
                  wait_cnt <= '0;
               end else if (!eng_lock && (!eng_req || wait_cnt == WAIT_LAST)) begin
                  state    <= WB_ACC;
                  wait_cnt <= '0;
               end else if (wait_cnt != WAIT_LAST) begin
                  // saturates so a lock release lets wishbone in on the next cycle
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            WB_ACC:  state <= WB_ACK;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      wb_ack     = 1'b0;
      wb_dat_o   = '0;
      eng_gnt    = 1'b0;
      mem_we_n   = 1'b1;
      mem_addr   = '0;
      mem_datain = '0;
      if (!RST) begin
         if (state == WB_ACC) begin
            // access completes even if the master drops wb_cyc here
            mem_we_n   = !wb_we;
            mem_addr   = wb_addr;
            mem_datain = wb_dat_i;
         end else begin
            if (state == WB_ACK) begin
               wb_ack   = wb_cyc & wb_stb;
               wb_dat_o = mem_dataout;
            end
            if (eng_req) begin
               eng_gnt    = 1'b1;
               mem_we_n   = eng_we_n;
               mem_addr   = eng_addr;
               mem_datain = eng_wdata;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: a behavioural memory, a scoreboard of expected acks
// popped by a negedge monitor, and per-cycle checks of the memory port.
module tb_mem_arb;

   logic        clk = 1'b0;
   logic        RST;
   logic        wb_cyc, wb_stb, wb_we;
   logic [4:0]  wb_addr;
   logic [31:0] wb_dat_i, wb_dat_o;
   logic        wb_ack;
   logic        eng_req, eng_lock, eng_we_n;
   logic [4:0]  eng_addr;
   logic [31:0] eng_wdata, eng_rdata;
   logic        eng_gnt;
   logic        mem_we_n;
   logic [4:0]  mem_addr;
   logic [31:0] mem_datain, mem_dataout;
   logic        mem_init;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int n;

   typedef struct packed {
      logic [31:0] at;
      logic [31:0] data;
      logic        chkd;
   } exp_t;
   exp_t sb[$];

   mem_arb #(.MAX_WAIT(8)) dut (
      .clk(clk), .RST(RST),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
      .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_ack(wb_ack),
      .eng_req(eng_req), .eng_lock(eng_lock), .eng_we_n(eng_we_n),
      .eng_addr(eng_addr), .eng_wdata(eng_wdata), .eng_gnt(eng_gnt),
      .eng_rdata(eng_rdata),
      .mem_we_n(mem_we_n), .mem_addr(mem_addr), .mem_datain(mem_datain),
      .mem_dataout(mem_dataout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // synchronous memory, read data one cycle after address
   logic [31:0] mem [32];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 | 32'(i);
      end else if (!mem_we_n) begin
         mem[mem_addr] <= mem_datain;
      end
      mem_dataout <= mem[mem_addr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() > 0 && sb[0].at < 32'(cyc)) begin
         tests++;
         fails++;
         $display("FAIL ack_timeout: got no ack, expected ack at cycle %0d", sb[0].at);
         void'(sb.pop_front());
      end
      if (wb_ack) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_ack: got ack at cycle %0d, expected none", cyc);
         end else begin
            e = sb.pop_front();
            chk("ack_cycle", cyc, e.at);
            if (e.chkd) chk("ack_data", wb_dat_o, e.data);
         end
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic wb_drive(input logic c, input logic s, input logic w,
                           input logic [4:0] a, input logic [31:0] d);
      wb_cyc = c; wb_stb = s; wb_we = w; wb_addr = a; wb_dat_i = d;
   endtask

   task automatic eng_drive(input logic r, input logic l, input logic wn,
                            input logic [4:0] a, input logic [31:0] d);
      eng_req = r; eng_lock = l; eng_we_n = wn; eng_addr = a; eng_wdata = d;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset with both requesters active: outputs must stay quiet
      RST = 1'b1;
      mem_init = 1'b1;
      wb_drive(1, 1, 1, 5'd4, 32'h4444_4444);
      eng_drive(1, 0, 0, 5'd7, 32'h7777_7777);
      @(negedge clk);
      chk("rst_ack", wb_ack, 0);
      chk("rst_gnt", eng_gnt, 0);
      chk("rst_we_n", mem_we_n, 1);
      chk("rst_addr", mem_addr, 0);
      chk("rst_datain", mem_datain, 0);
      chk("rst_dat_o", wb_dat_o, 0);
      nxt();
      RST = 1'b0;
      mem_init = 1'b0;
      wb_drive(0, 0, 0, 0, 0);
      eng_drive(0, 0, 1, 0, 0);
      @(negedge clk);
      chk("idle_we_n", mem_we_n, 1);
      chk("idle_addr", mem_addr, 0);
      chk("idle_rdata", eng_rdata, mem_dataout);
      nxt();

      // uncontended write then read
      wb_drive(1, 1, 1, 5'd5, 32'hDEAD_BEEF);
      n = cyc;
      sb.push_back('{32'(n + 2), 32'h0, 1'b0});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t1_we_n", mem_we_n, (i == 1) ? 32'd0 : 32'd1);
         chk("t1_addr", mem_addr, (i == 1) ? 32'd5 : 32'd0);
         chk("t1_gnt", eng_gnt, 0);
         nxt();
      end
      wb_drive(0, 0, 0, 0, 0);
      wb_drive(1, 1, 0, 5'd5, 32'h0);
      n = cyc;
      sb.push_back('{32'(n + 2), 32'hDEAD_BEEF, 1'b1});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (i == 0) chk("t1_dat_o_idle", wb_dat_o, 0);
         chk("t1_rdata", eng_rdata, mem_dataout);
         nxt();
      end
      wb_drive(0, 0, 0, 0, 0);

      // engine writes every cycle; wishbone read gets in after 8 waits
      eng_drive(1, 0, 0, 5'd9, 32'hCAFE_0009);
      wb_drive(1, 1, 0, 5'd5, 32'h0);
      n = cyc;
      sb.push_back('{32'(n + 9), 32'hDEAD_BEEF, 1'b1});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t2_gnt", eng_gnt, (i == 8) ? 32'd0 : 32'd1);
         chk("t2_addr", mem_addr, (i == 8) ? 32'd5 : 32'd9);
         chk("t2_we_n", mem_we_n, (i == 8) ? 32'd1 : 32'd0);
         chk("t2_datain", mem_datain, (i == 8) ? 32'h0 : 32'hCAFE_0009);
         nxt();
      end
      wb_drive(0, 0, 0, 0, 0);

      // a dropped request must clear the wait count
      eng_drive(1, 0, 1, 5'd9, 32'h0);
      wb_drive(1, 1, 0, 5'd5, 32'h0);
      nxt(); nxt(); nxt();
      wb_drive(0, 0, 0, 0, 0);
      nxt();
      wb_drive(1, 1, 0, 5'd5, 32'h0);
      n = cyc;
      sb.push_back('{32'(n + 9), 32'hDEAD_BEEF, 1'b1});
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("t7_gnt", eng_gnt, (i == 8) ? 32'd0 : 32'd1);
         nxt();
      end
      wb_drive(0, 0, 0, 0, 0);

      // engine lock for 20 cycles: no wishbone access until it releases
      eng_drive(1, 1, 1, 5'd9, 32'h0);
      wb_drive(1, 1, 0, 5'd9, 32'h0);
      n = cyc;
      sb.push_back('{32'(n + 22), 32'hCAFE_0009, 1'b1});
      for (int i = 0; i < 23; i++) begin
         if (i == 20) eng_lock = 1'b0;
         @(negedge clk);
         chk("t3_gnt", eng_gnt, (i == 21) ? 32'd0 : 32'd1);
         nxt();
      end
      wb_drive(0, 0, 0, 0, 0);
      eng_drive(0, 0, 1, 0, 0);

      // strobe held high across acks: one access per three cycles
      wb_drive(1, 1, 0, 5'd5, 32'h0);
      n = cyc;
      for (int k = 0; k < 3; k++) sb.push_back('{32'(n + 2 + 3 * k), 32'hDEAD_BEEF, 1'b1});
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         chk("t4_addr", mem_addr, (i % 3 == 1) ? 32'd5 : 32'd0);
         nxt();
      end
      wb_drive(0, 0, 0, 0, 0);

      // cycle dropped during the access: write lands, no ack
      wb_drive(1, 1, 1, 5'd3, 32'h3333_3333);
      nxt();
      wb_cyc = 1'b0;
      wb_stb = 1'b0;
      @(negedge clk);
      chk("t6_we_n", mem_we_n, 0);
      chk("t6_addr", mem_addr, 3);
      chk("t6_datain", mem_datain, 32'h3333_3333);
      nxt();
      @(negedge clk);
      chk("t6_ack", wb_ack, 0);
      nxt();
      wb_drive(1, 1, 0, 5'd3, 32'h0);
      n = cyc;
      sb.push_back('{32'(n + 2), 32'h3333_3333, 1'b1});
      nxt(); nxt(); nxt();
      wb_drive(0, 0, 0, 0, 0);

      // reset during the access aborts it; the held strobe restarts afterwards
      wb_drive(1, 1, 1, 5'd12, 32'h1212_1212);
      n = cyc;
      sb.push_back('{32'(n + 4), 32'h0, 1'b0});
      nxt();
      RST = 1'b1;
      @(negedge clk);
      chk("t5_we_n", mem_we_n, 1);
      chk("t5_addr", mem_addr, 0);
      chk("t5_ack", wb_ack, 0);
      nxt();
      RST = 1'b0;
      @(negedge clk);
      chk("t5_idle_we_n", mem_we_n, 1);
      nxt();
      @(negedge clk);
      chk("t5_retry_we_n", mem_we_n, 0);
      chk("t5_retry_addr", mem_addr, 12);
      nxt();
      nxt();
      wb_drive(0, 0, 0, 0, 0);

      nxt(); nxt(); nxt();
      chk("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
